dmem_lsu: RTL and testbench

- Load/store unit between the multicycle core datapath and the 64-bit data memory.
- Takes one request per access from the control unit: ALU-register address, rs2 store data, size and signedness.
- Aligns and extends load data into a 64-bit value for the register-file write mux.
- Stores narrower than a doubleword are done by read-modify-write, because the data memory only writes full 64-bit words.

---
 rtl/dmem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the multicycle core datapath and the 64-bit data memory.
// Loads are aligned and sign/zero-extended; sub-doubleword stores use read-modify-write.
// Optional feature macro: DMEM_LSU_WSTRB_EN adds mem_wstrb and replaces read-modify-write
// with a single strobed write.
module dmem_lsu #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_wr,
`ifdef DMEM_LSU_WSTRB_EN
    output logic [7:0]        mem_wstrb,
`endif
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  lane_q;
    logic [63:0] wdata_q;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        unique case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            default: return a != 3'b000;
        endcase
    endfunction

    // Byte-lane mask; only called for aligned accesses so the shift never spills.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] m;
        unique case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m << lane;
    endfunction

    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] w);
        unique case (size)
            2'b00:   return {8{w[7:0]}};
            2'b01:   return {4{w[15:0]}};
            2'b10:   return {2{w[31:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [63:0] bit_mask(input logic [7:0] m);
        logic [63:0] bm;
        for (int i = 0; i < 8; i++) begin
            bm[8*i +: 8] = {8{m[i]}};
        end
        return bm;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                           input logic [2:0] lane, input logic uns);
        logic [63:0] s;
        s = d >> {lane, 3'b000};
        unique case (size)
            2'b00:   return uns ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            2'b01:   return uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'b10:   return uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    logic [63:0] merge_mask;
    logic [63:0] merged;

    // Read-modify-write merge of the latched store data into the fetched doubleword.
    always_comb begin
        merge_mask = bit_mask(lane_mask(size_q, lane_q));
        merged     = (replicate(size_q, wdata_q) & merge_mask) | (mem_rdata & ~merge_mask);
    end

`ifdef DMEM_LSU_WSTRB_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Control FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            lane_q        <= '0;
            wdata_q       <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wr        <= 1'b0;
`ifdef DMEM_LSU_WSTRB_EN
            mem_wstrb     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        lane_q    <= req_addr[2:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_misaligned(req_size, req_addr[2:0])) begin
                            state_q       <= StResp;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
`ifdef DMEM_LSU_WSTRB_EN
                            if (req_we) begin
                                state_q   <= StWrite;
                                mem_wr    <= 1'b1;
                                mem_wdata <= replicate(req_size, req_wdata);
                                mem_wstrb <= lane_mask(req_size, req_addr[2:0]);
                            end
`else
                            if (req_we && req_size == 2'b11) begin
                                state_q   <= StWrite;
                                mem_wr    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end
`endif
                            else begin
                                state_q <= StRdWait;
                                cnt_q   <= 3'(MEM_LATENCY - 1);
                            end
                        end
                    end
                end
                StRdWait: begin
                    if (cnt_q == 3'd0) begin
                        if (we_q) begin
                            state_q   <= StWrite;
                            mem_wr    <= 1'b1;
                            mem_wdata <= merged;
                        end else begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= extend(mem_rdata, size_q, lane_q, uns_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StWrite: begin
                    state_q    <= StResp;
                    mem_wr     <= 1'b0;
                    mem_wdata  <= '0;
`ifdef DMEM_LSU_WSTRB_EN
                    mem_wstrb  <= '0;
`endif
                    resp_valid <= 1'b1;
                end
                default: begin
                    state_q       <= StIdle;
                    resp_valid    <= 1'b0;
                    resp_rdata    <= '0;
                    resp_misalign <= 1'b0;
                    mem_addr      <= '0;
                    req_ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural 16-doubleword memory.
module tb_dmem_lsu;

`ifdef DMEM_LSU_WSTRB_EN
    localparam int unsigned LAT   = 3;
    localparam bit          WSTRB = 1'b1;
`else
    localparam int unsigned LAT   = 1;
    localparam bit          WSTRB = 1'b0;
`endif
    localparam int PS_CYC = WSTRB ? 2 : 2 + LAT;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misalign;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;
`ifdef DMEM_LSU_WSTRB_EN
    logic [7:0]  mem_wstrb;
`endif

    logic [63:0] mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wdata_leak = 0;

    dmem_lsu #(
        .MEM_LATENCY (LAT),
        .ADDR_W      (64)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wr        (mem_wr),
`ifdef DMEM_LSU_WSTRB_EN
        .mem_wstrb     (mem_wstrb),
`endif
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[6:3]];

    always @(posedge clock) begin
        if (mem_wr) begin
`ifdef DMEM_LSU_WSTRB_EN
            for (int i = 0; i < 8; i++) begin
                if (mem_wstrb[i]) mem[mem_addr[6:3]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
`else
            mem[mem_addr[6:3]] <= mem_wdata;
`endif
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Present one request and return just after the accepting edge with inputs scrambled.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clock);
        check_val("ready", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = 64'h7;
        req_wdata    = ~wdata;
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_mis, input int exp_cyc,
                       input int exp_wr_n, input logic [63:0] exp_wdata,
                       input logic [7:0] exp_strb);
        int          cyc;
        int          wr_n;
        int          wr_cyc;
        logic [63:0] rdata;
        logic [63:0] wr_data;
        logic        mis;
        logic [7:0]  wr_strb;
        cyc = -1; wr_n = 0; wr_cyc = -1; rdata = '0; wr_data = '0; mis = 1'b0; wr_strb = '0;
        send(we, size, uns, addr, wdata);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (mem_wr) begin
                wr_n++;
                wr_cyc  = n;
                wr_data = mem_wdata;
`ifdef DMEM_LSU_WSTRB_EN
                wr_strb = mem_wstrb;
`endif
            end else if (mem_wdata != 64'd0) begin
                wdata_leak++;
            end
            if (resp_valid) begin
                cyc   = n;
                rdata = resp_rdata;
                mis   = resp_misalign;
                break;
            end
        end
        if (cyc < 0) check_val({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
        check_val({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        check_val({tag, "_rdata"}, rdata, exp_rdata);
        check_val({tag, "_mis"}, 64'(mis), 64'(exp_mis));
        check_val({tag, "_wr_n"}, 64'(wr_n), 64'(exp_wr_n));
        if (exp_wr_n != 0) begin
            check_val({tag, "_wr_cyc"}, 64'(wr_cyc), 64'(exp_cyc - 1));
            check_val({tag, "_wdata"}, wr_data, exp_wdata);
`ifdef DMEM_LSU_WSTRB_EN
            check_val({tag, "_strb"}, 64'(wr_strb), 64'(exp_strb));
`else
            if (exp_strb == 8'h00) wr_strb = 8'h00;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        mem[0] = 64'h0123_4567_89ab_cdef;
        mem[2] = 64'hf077_6655_4433_2211;
        mem[4] = 64'h1111_1111_1111_1111;
        mem[6] = 64'h0706_0504_0302_0100;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_mem_wr", 64'(mem_wr), 64'd0);
        check_val("rst_mem_addr", mem_addr, 64'd0);
        check_val("rst_rdata", resp_rdata, 64'd0);
        reset = 1'b1;

        // Loads: byte, byte at lane 7 signed/unsigned, half signed, word unsigned.
        run("lb_15", 0, 2'b00, 0, 64'h15, 0, 64'h66, 0, 1 + LAT, 0, 0, 0);
        run("lb_17", 0, 2'b00, 0, 64'h17, 0, 64'hffff_ffff_ffff_fff0, 0, 1 + LAT, 0, 0, 0);
        run("lbu_17", 0, 2'b00, 1, 64'h17, 0, 64'h0000_0000_0000_00f0, 0, 1 + LAT, 0, 0, 0);
        run("lh_16", 0, 2'b01, 0, 64'h16, 0, 64'hffff_ffff_ffff_f077, 0, 1 + LAT, 0, 0, 0);
        run("lwu_14", 0, 2'b10, 1, 64'h14, 0, 64'h0000_0000_f077_6655, 0, 1 + LAT, 0, 0, 0);

        // Half store into the middle of a doubleword, then read back.
        run("sh_22", 1, 2'b01, 0, 64'h22, 64'h1234_5678_9abc_abcd, 0, 0, PS_CYC, 1,
            WSTRB ? 64'habcd_abcd_abcd_abcd : 64'h1111_1111_abcd_1111, 8'h0c);
        check_val("sh_22_mem", mem[4], 64'h1111_1111_abcd_1111);
        run("lwu_20", 0, 2'b10, 1, 64'h20, 0, 64'h0000_0000_abcd_1111, 0, 1 + LAT, 0, 0, 0);

        // Misaligned word load: immediate fault, no memory traffic.
        run("lw_06", 0, 2'b10, 0, 64'h06, 0, 0, 1, 1, 0, 0, 0);
        check_val("lw_06_mem", mem[0], 64'h0123_4567_89ab_cdef);

        // Full store then back-to-back load of the same doubleword.
        run("sd_40", 1, 2'b11, 0, 64'h40, 64'hdead_beef_cafe_f00d, 0, 0, 2, 1,
            64'hdead_beef_cafe_f00d, 8'hff);
        run("ld_40", 0, 2'b11, 1, 64'h40, 0, 64'hdead_beef_cafe_f00d, 0, 1 + LAT, 0, 0, 0);

        // Byte store at lane 3 and readback.
        run("sb_33", 1, 2'b00, 0, 64'h33, 64'h0000_0000_0000_c35a, 0, 0, PS_CYC, 1,
            WSTRB ? 64'h5a5a_5a5a_5a5a_5a5a : 64'h0706_0504_5a02_0100, 8'h08);
        run("ld_30", 0, 2'b11, 0, 64'h30, 0, 64'h0706_0504_5a02_0100, 0, 1 + LAT, 0, 0, 0);

`ifndef DMEM_LSU_WSTRB_EN
        // Reset during the read phase of a byte store must abandon it cleanly.
        begin
            int hits;
            hits = 0;
            send(1, 2'b00, 0, 64'h31, 64'hee);
            @(negedge clock);
            reset = 1'b0;
            #1;
            check_val("rmw_rst_mem_wr", 64'(mem_wr), 64'd0);
            check_val("rmw_rst_resp", 64'(resp_valid), 64'd0);
            check_val("rmw_rst_ready", 64'(req_ready), 64'd1);
            repeat (2) @(negedge clock);
            reset = 1'b1;
            for (int n = 0; n < 6; n++) begin
                @(negedge clock);
                if (mem_wr || resp_valid) hits++;
            end
            check_val("rmw_rst_quiet", 64'(hits), 64'd0);
            check_val("rmw_rst_mem", mem[6], 64'h0706_0504_5a02_0100);
            run("ld_30_post", 0, 2'b11, 0, 64'h30, 0, 64'h0706_0504_5a02_0100, 0, 1 + LAT,
                0, 0, 0);
        end
`endif

        check_val("wdata_idle", 64'(wdata_leak), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
